varint_encoder: RTL and testbench

//   Downstream stage of the AXI write-slave FSM. Drains the varint input FIFOs (data/index/size)

---
 rtl/varint_pkg.sv | 15 +
 rtl/varint_encoder.sv | 108 ++++++++++
 tb/tb_varint_encoder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/varint_pkg.sv
// rtl/varint_pkg.sv - shared constants and state encoding for the varint encoder
package varint_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_HI = 2'd1,
      ST_EMIT    = 2'd2
   } state_t;

   localparam int VARINT_GRP_W       = 7;
   localparam int VARINT_MAX_BYTES32 = 5;
   localparam int VARINT_MAX_BYTES64 = 10;
   localparam int CONT_BIT           = 7;

endpackage

// File: rtl/varint_encoder.sv
// rtl/varint_encoder.sv - drains the varint FIFO set and emits protobuf base-128 varint bytes
module varint_encoder
   import varint_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int INDEX_W = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               vi_empty,
   input  logic [DATA_W-1:0]  vi_data,
   input  logic [INDEX_W-1:0] vi_index,
   input  logic               vi_size64,
   output logic               vi_pop,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [7:0]         out_byte,
   output logic [INDEX_W-1:0] out_index,
   output logic               out_last,
   output logic               busy,
   output logic               size_err
);

   localparam int SR_W = 2 * DATA_W;

   state_t               state_q, state_d;
   logic [SR_W-1:0]      sr_q, sr_d;
   logic [INDEX_W-1:0]   idx_q, idx_d;
   logic                 err_q, err_d;
   logic                 pop_c;
   logic                 more;
   logic                 emit;
   logic [7:0]           byte_c;

   assign more = |sr_q[SR_W-1:VARINT_GRP_W];
   assign emit = (state_q == ST_EMIT);

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      idx_d   = idx_q;
      err_d   = err_q;
      pop_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!vi_empty) begin
               pop_c   = 1'b1;
               sr_d    = {{DATA_W{1'b0}}, vi_data};
               idx_d   = vi_index;
               state_d = vi_size64 ? ST_WAIT_HI : ST_EMIT;
            end
         end
         ST_WAIT_HI: begin
            // A missing size64 flag is flagged but the word is still taken as the high half.
            if (!vi_empty) begin
               pop_c                   = 1'b1;
               sr_d[SR_W-1:DATA_W]     = vi_data;
               if (!vi_size64) err_d   = 1'b1;
               state_d                 = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (out_ready) begin
               sr_d = sr_q >> VARINT_GRP_W;
               if (!more) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (clr) begin
         state_d = ST_IDLE;
         sr_d    = '0;
         idx_d   = '0;
         err_d   = 1'b0;
         pop_c   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      byte_c           = {1'b0, sr_q[VARINT_GRP_W-1:0]};
      byte_c[CONT_BIT] = more;
   end

   // Reset gates the pop so the FIFOs are never drained while the encoder is held.
   assign vi_pop    = pop_c & reset;
   assign out_valid = emit;
   assign out_byte  = emit ? byte_c : 8'h00;
   assign out_index = emit ? idx_q : '0;
   assign out_last  = emit & ~more;
   assign busy      = (state_q != ST_IDLE);
   assign size_err  = err_q;

endmodule

// File: tb/tb_varint_encoder.sv
// tb/tb_varint_encoder.sv - scoreboard bench for varint_encoder with a FIFO model and random values
module tb_varint_encoder;

   logic        clk = 1'b0;
   logic        reset, clr, vi_empty, vi_size64, vi_pop;
   logic [31:0] vi_data;
   logic [9:0]  vi_index, out_index;
   logic        out_valid, out_ready, out_last, busy, size_err;
   logic [7:0]  out_byte;

   typedef struct { logic [31:0] d; logic [9:0] i; logic s; } fent_t;
   typedef struct { logic [7:0] b; logic [9:0] i; logic l; } exp_t;

   fent_t fifo_q[$];
   exp_t  exp_q[$];
   int    tests = 0, fails = 0, pops = 0, hs_cnt = 0, ready_mode = 0;

   varint_encoder #(.DATA_W(32), .INDEX_W(10)) dut (
      .clk(clk), .reset(reset), .clr(clr),
      .vi_empty(vi_empty), .vi_data(vi_data), .vi_index(vi_index), .vi_size64(vi_size64),
      .vi_pop(vi_pop), .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
      .out_index(out_index), .out_last(out_last), .busy(busy), .size_err(size_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: repeatedly take value mod 128, continuation when anything remains.
   task automatic model_push(input logic [63:0] v, input logic [9:0] idx);
      longint unsigned r = v;
      exp_t e;
      do begin
         e.b = 8'(r % 128);
         r   = r / 128;
         if (r != 0) e.b = e.b + 8'd128;
         e.i = idx;
         e.l = (r == 0);
         exp_q.push_back(e);
      end while (r != 0);
   endtask

   task automatic push32(input logic [31:0] v, input logic [9:0] idx);
      fifo_q.push_back('{v, idx, 1'b0});
      model_push({32'h0, v}, idx);
   endtask

   task automatic push64(input logic [63:0] v, input logic [9:0] idx, input logic hi_s);
      fifo_q.push_back('{v[31:0], idx, 1'b1});
      fifo_q.push_back('{v[63:32], 10'($urandom), hi_s});
      model_push(v, idx);
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0 || busy) && n < 3000) begin
         @(negedge clk); #3;
         n++;
      end
      chk({nm, "_timeout"}, 64'(n < 3000), 64'd1);
   endtask

   // FIFO model and ready generation: inputs change on negedge, pop decided just after.
   always @(negedge clk) begin
      vi_empty = (fifo_q.size() == 0);
      if (fifo_q.size() != 0) begin
         vi_data   = fifo_q[0].d;
         vi_index  = fifo_q[0].i;
         vi_size64 = fifo_q[0].s;
      end else begin
         vi_data   = 32'h0;
         vi_index  = 10'h0;
         vi_size64 = 1'b0;
      end
      out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (vi_pop) begin
         chk("pop_not_empty", 64'(vi_empty), 64'd0);
         if (!vi_empty) begin
            void'(fifo_q.pop_front());
            pops++;
         end
      end
   end

   // Monitor: compares every accepted byte against the scoreboard and checks hold stability.
   logic       prev_hold = 1'b0;
   logic [7:0] prev_b;
   logic [9:0] prev_i;
   logic       prev_l;
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (reset && !clr) begin
         if (prev_hold) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_byte", 64'(out_byte), 64'(prev_b));
            chk("hold_index", 64'(out_index), 64'(prev_i));
            chk("hold_last", 64'(out_last), 64'(prev_l));
         end
         if (out_valid && out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", 64'(out_byte), 64'hx);
            end else begin
               e = exp_q.pop_front();
               chk("out_byte", 64'(out_byte), 64'(e.b));
               chk("out_index", 64'(out_index), 64'(e.i));
               chk("out_last", 64'(out_last), 64'(e.l));
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_b    = out_byte;
         prev_i    = out_index;
         prev_l    = out_last;
      end else begin
         prev_hold = 1'b0;
      end
   end

   task automatic abort_after_two(input bit use_reset);
      int target, n;
      push32(32'h1234_5678, 10'd7);
      target = hs_cnt + 2;
      n = 0;
      while (hs_cnt < target && n < 100) begin @(negedge clk); #3; n++; end
      chk("abort_wait_timeout", 64'(n < 100), 64'd1);
      @(negedge clk);
      if (use_reset) begin
         reset = 1'b0;
         #1;
         chk("rst_async_valid", 64'(out_valid), 64'd0);
         chk("rst_async_busy", 64'(busy), 64'd0);
         @(negedge clk);
         reset = 1'b1;
      end else begin
         clr = 1'b1;
         @(negedge clk);
         clr = 1'b0;
         #1;
         chk("clr_valid", 64'(out_valid), 64'd0);
         chk("clr_busy", 64'(busy), 64'd0);
         chk("clr_size_err", 64'(size_err), 64'd0);
      end
      chk("abort_bytes_left", 64'(exp_q.size()), 64'd3);
      exp_q.delete();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         chk("abort_no_pop", 64'(vi_pop), 64'd0);
         chk("abort_idle", 64'(busy), 64'd0);
      end
      push32(32'($urandom), 10'($urandom));
      drain("abort_next");
   endtask

   function automatic logic [63:0] pick_val(input bit is64);
      logic [63:0] v;
      int k;
      case ($urandom_range(0, 4))
         0: v = 64'($urandom_range(0, 300));
         1: begin
            k = $urandom_range(1, 9);
            v = (64'd1 << (7 * k)) - 64'(($urandom_range(0, 1)));
         end
         2: v = {32'($urandom), 32'($urandom)};
         3: v = '1;
         default: v = 64'd0;
      endcase
      if (!is64) v = {32'h0, v[31:0]};
      return v;
   endfunction

   initial begin
      int p0;
      reset = 1'b0; clr = 1'b0;
      push32(32'h0000_0001, 10'd3);
      repeat (3) @(negedge clk);
      #1;
      chk("rst_vi_pop", 64'(vi_pop), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_size_err", 64'(size_err), 64'd0);
      chk("rst_out_byte", 64'(out_byte), 64'd0);
      chk("rst_out_index", 64'(out_index), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      drain("t1");
      chk("t1_pops", 64'(pops), 64'd1);

      push32(32'd300, 10'd5);
      drain("t2");

      p0 = pops;
      push32(32'h1234_5678, 10'd7);
      drain("t3");
      chk("t3_pops", 64'(pops - p0), 64'd1);

      p0 = pops;
      fifo_q.push_back('{32'hFFFF_FFFF, 10'd11, 1'b1});
      model_push('1, 10'd11);
      begin
         int n = 0;
         while (fifo_q.size() != 0 && n < 50) begin @(negedge clk); #3; n++; end
      end
      repeat (3) begin
         @(negedge clk); #1;
         chk("t4_wait_busy", 64'(busy), 64'd1);
         chk("t4_wait_valid", 64'(out_valid), 64'd0);
         chk("t4_wait_pop", 64'(vi_pop), 64'd0);
      end
      fifo_q.push_back('{32'hFFFF_FFFF, 10'd600, 1'b1});
      drain("t4");
      chk("t4_pops", 64'(pops - p0), 64'd2);
      chk("t4_size_err", 64'(size_err), 64'd0);

      ready_mode = 2;
      push32(32'd0, 10'd9);
      repeat (3) @(negedge clk);
      repeat (3) begin
         @(negedge clk); #3;
         chk("t5_valid", 64'(out_valid), 64'd1);
         chk("t5_byte", 64'(out_byte), 64'd0);
         chk("t5_last", 64'(out_last), 64'd1);
      end
      ready_mode = 0;
      drain("t5");
      chk("t5_idle", 64'(busy), 64'd0);

      push64(64'h0000_0001_0000_0080, 10'd21, 1'b0);
      drain("serr");
      chk("serr_sticky", 64'(size_err), 64'd1);

      abort_after_two(1'b0);
      abort_after_two(1'b1);

      ready_mode = 1;
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 1) == 1) push64(pick_val(1'b1), 10'($urandom), 1'b1);
         else push32(32'(pick_val(1'b0)), 10'($urandom));
         if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
      end
      drain("random");
      chk("random_size_err", 64'(size_err), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
